// File: rtl/polynomial_finder_scheduler_pkg.sv
// Shared constants and state encoding for the polynomial finder scheduler.
package polynomial_finder_scheduler_pkg;

  localparam int DATA_W = 17;
  localparam int TS_W   = 24;

  localparam logic [DATA_W-1:0] POLY_A = 17'h1d258;
  localparam logic [DATA_W-1:0] POLY_B = 17'h17e04;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RELEASE   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/polynomial_finder_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_SENSORS = 4,
  parameter int ID_W        = 2
) (
  input  logic [NUM_SENSORS-1:0] req_i,
  input  logic [ID_W-1:0]        ptr_i,
  output logic [NUM_SENSORS-1:0] grant_o,
  output logic [ID_W-1:0]        idx_o,
  output logic                   any_o
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      cand = ID_W'((int'(ptr_i) + k) % NUM_SENSORS);
      if (!any_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/polynomial_finder_scheduler.sv
// Round-robin scheduler sharing one polynomial finder between NUM_SENSORS channels.
// Optional watchdog with res_timeout output: define POLY_SCHED_TIMEOUT_EN.
module polynomial_finder_scheduler
  import polynomial_finder_scheduler_pkg::*;
#(
  parameter int          NUM_SENSORS    = 4,
  parameter int          ID_W           = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
  input  logic                          clk_96MHz,
  input  logic                          reset,
  input  logic [NUM_SENSORS-1:0]        req_valid,
  output logic [NUM_SENSORS-1:0]        req_ack,
  input  logic [DATA_W*NUM_SENSORS-1:0] req_data,
  input  logic [DATA_W*NUM_SENSORS-1:0] req_data1,
  input  logic [TS_W*NUM_SENSORS-1:0]   req_ts,
  input  logic [TS_W*NUM_SENSORS-1:0]   req_ts1,
  output logic [DATA_W-1:0]             pf_decoded_data,
  output logic [DATA_W-1:0]             pf_decoded_data1,
  output logic [TS_W-1:0]               pf_ts_last_data,
  output logic [TS_W-1:0]               pf_ts_last_data1,
  output logic                          pf_enable,
  input  logic                          pf_ready,
  input  logic [DATA_W-1:0]             pf_polynomial,
  input  logic [DATA_W-1:0]             pf_iteration_number,
  output logic                          res_valid,
  output logic [ID_W-1:0]               res_sensor_id,
  output logic [DATA_W-1:0]             res_polynomial,
  output logic [DATA_W-1:0]             res_iteration,
  output logic                          res_found,
`ifdef POLY_SCHED_TIMEOUT_EN
  output logic                          res_timeout,
`endif
  output logic                          busy
);

  if (ID_W != $clog2(NUM_SENSORS) || TIMEOUT_CYCLES == 16'd0) begin : g_bad_params
    $error("polynomial_finder_scheduler: ID_W must equal clog2(NUM_SENSORS) and TIMEOUT_CYCLES must be nonzero");
  end

  sched_state_e            state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic                    pf_enable_q, pf_enable_d;
  logic [DATA_W-1:0]       data0_q, data0_d, data1_q, data1_d;
  logic [TS_W-1:0]         ts0_q, ts0_d, ts1_q, ts1_d;
  logic [DATA_W-1:0]       poly_q, poly_d, iter_q, iter_d;
  logic                    rel_rdy_q, rel_rdy_d;
  logic [NUM_SENSORS-1:0]  gnt_onehot;
  logic [ID_W-1:0]         gnt_idx;
  logic                    gnt_any;
`ifdef POLY_SCHED_TIMEOUT_EN
  logic [15:0]             wd_cnt_q, wd_cnt_d;
  logic                    timeout_q, timeout_d;
`endif

  rr_arbiter #(
    .NUM_SENSORS (NUM_SENSORS),
    .ID_W        (ID_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt_onehot),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    pf_enable_d = pf_enable_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    ts0_d       = ts0_q;
    ts1_d       = ts1_q;
    poly_d      = poly_q;
    iter_d      = iter_q;
    rel_rdy_d   = 1'b0;
    req_ack     = '0;
    res_valid   = 1'b0;
`ifdef POLY_SCHED_TIMEOUT_EN
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pf_ready && gnt_any) begin
          req_ack  = gnt_onehot;
          id_d     = gnt_idx;
          data0_d  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
          data1_d  = req_data1[int'(gnt_idx)*DATA_W +: DATA_W];
          ts0_d    = req_ts[int'(gnt_idx)*TS_W +: TS_W];
          ts1_d    = req_ts1[int'(gnt_idx)*TS_W +: TS_W];
          rr_ptr_d = (gnt_idx == ID_W'(NUM_SENSORS - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = S_START;
`ifdef POLY_SCHED_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      S_START: begin
        pf_enable_d = 1'b1;
        state_d     = S_WAIT_BUSY;
`ifdef POLY_SCHED_TIMEOUT_EN
        wd_cnt_d    = '0;
`endif
      end
      S_WAIT_BUSY: begin
        if (!pf_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (pf_ready) begin
          poly_d      = pf_polynomial;
          iter_d      = (pf_polynomial == '0) ? '0 : pf_iteration_number;
          pf_enable_d = 1'b0;
          state_d     = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // The finder must show ready for two consecutive cycles with enable low.
        rel_rdy_d = pf_ready;
        if (pf_ready && rel_rdy_q) begin
          res_valid = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef POLY_SCHED_TIMEOUT_EN
    if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) begin
      if (wd_cnt_q == TIMEOUT_CYCLES) begin
        pf_enable_d = 1'b0;
        poly_d      = '0;
        iter_d      = '0;
        timeout_d   = 1'b1;
        state_d     = S_RELEASE;
      end else begin
        wd_cnt_d = wd_cnt_q + 16'd1;
      end
    end
    if (state_q == S_RELEASE && timeout_q) begin
      res_valid = 1'b1;
      state_d   = S_IDLE;
    end
`endif
    // An in-flight job is discarded while reset is held.
    if (reset) begin
      req_ack   = '0;
      res_valid = 1'b0;
    end
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      pf_enable_q <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      ts0_q       <= '0;
      ts1_q       <= '0;
      poly_q      <= '0;
      iter_q      <= '0;
      rel_rdy_q   <= 1'b0;
`ifdef POLY_SCHED_TIMEOUT_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      pf_enable_q <= pf_enable_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      ts0_q       <= ts0_d;
      ts1_q       <= ts1_d;
      poly_q      <= poly_d;
      iter_q      <= iter_d;
      rel_rdy_q   <= rel_rdy_d;
`ifdef POLY_SCHED_TIMEOUT_EN
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign pf_enable        = pf_enable_q;
  assign pf_decoded_data  = data0_q;
  assign pf_decoded_data1 = data1_q;
  assign pf_ts_last_data  = ts0_q;
  assign pf_ts_last_data1 = ts1_q;
  assign res_sensor_id    = id_q;
  assign res_polynomial   = poly_q;
  assign res_iteration    = iter_q;
  assign res_found        = (poly_q != '0);
  assign busy             = (state_q != S_IDLE);
`ifdef POLY_SCHED_TIMEOUT_EN
  assign res_timeout      = res_valid & timeout_q;
`endif

endmodule

// File: doc/polynomial_finder_scheduler.md
Name: polynomial_finder_scheduler

Overview:
Shares one polynomial_finder instance between NUM_SENSORS photodiode channels. Each channel posts a pair of consecutive decoded LFSR words with their timestamps. The scheduler grants pairs in round-robin order, latches them, and sequences the finder's enable/ready handshake. It then returns the identified polynomial and iteration count, tagged with the sensor id, to the downstream angle/pose logic.

Parameters:
NUM_SENSORS, 4, number of requesting channels (2..16)
ID_W, 2, width of sensor id; must equal clog2(NUM_SENSORS)
TIMEOUT_CYCLES, 16'd40000, watchdog limit per job in clk_96MHz cycles (used only with the optional feature)

Ports:
clk_96MHz  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_SENSORS  channel i has a pair pending; held until its ack
req_ack  out  NUM_SENSORS  one-cycle pulse; pair of channel i captured this cycle
req_data  in  17*NUM_SENSORS  first decoded word, channel i at bits [17i+16:17i]
req_data1  in  17*NUM_SENSORS  second decoded word
req_ts  in  24*NUM_SENSORS  timestamp of first word
req_ts1  in  24*NUM_SENSORS  timestamp of second word
pf_decoded_data, pf_decoded_data1  out  17  to finder
pf_ts_last_data, pf_ts_last_data1  out  24  to finder
pf_enable  out  1  finder enable
pf_ready  in  1  finder ready
pf_polynomial  in  17  finder result; 0 = not found
pf_iteration_number  in  17  finder result
res_valid  out  1  one-cycle result strobe
res_sensor_id  out  ID_W  channel of result
res_polynomial  out  17  17'h1d258, 17'h17e04, or 0
res_iteration  out  17  iteration count; 0 if not found
res_found  out  1  res_polynomial != 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state=IDLE, rr_ptr=0, latched pair registers=0. Reset mid-job drops pf_enable next edge; the finder returns to IDLE on its own; the in-flight job is discarded and produces no res_valid.
- rr_ptr is the lowest-priority-after-last-grant pointer: the search starts at (last_granted+1) mod NUM_SENSORS.
- States:
  - IDLE: if pf_ready=1 and any req_valid: pick the first valid channel from the search start; pulse req_ack[g]; latch the four fields and id g; update rr_ptr; go to START. Otherwise stay.
  - START: pf_enable<=1; go to WAIT_BUSY.
  - WAIT_BUSY: wait for pf_ready=0 (finder has left its IDLE); go to WAIT_DONE.
  - WAIT_DONE: on pf_ready=1, capture pf_polynomial and pf_iteration_number; pf_enable<=0; go to RELEASE.
  - RELEASE: wait for pf_ready=1 with pf_enable=0 for one full cycle (finder back in its IDLE); pulse res_valid with the captured values; go to IDLE.
- pf_* data outputs are driven from the latched registers, stable from START until IDLE. Requesters may change req_* after ack.
- Grant-to-result latency is at least 5 cycles plus finder run time. Back-to-back jobs: the next grant can occur in the cycle after res_valid.
- Equal words or equal timestamps: the finder returns immediately with polynomial 0. This is reported as res_found=0, not treated as an error.
- req_valid dropping before ack: the request is simply not granted. No state is held per channel.
- Timestamp wrap is handled inside the finder; the scheduler passes timestamps unchanged.

Optional Feature:
POLY_SCHED_TIMEOUT_EN
- Defined: a 16-bit counter clears at START and increments in WAIT_BUSY/WAIT_DONE. Reaching TIMEOUT_CYCLES forces pf_enable<=0 and a move to RELEASE with polynomial=0 and iteration=0. An extra output `res_timeout` (1 bit) is high with that res_valid.
- Undefined: no counter and no `res_timeout` port; the scheduler waits indefinitely.

Decomposition:
- Shared package/header `vive_defs.vh`:
  - POLY_A = 17'h1d258, POLY_B = 17'h17e04
  - field widths DATA_W = 17, TS_W = 24
  - scheduler state encodings
- One sub-module, `rr_arbiter` (NUM_SENSORS request vector + pointer -> one-hot grant + index). It is combinational and reused by future shared-resource schedulers.

Test Plan:
1. Bench uses a behavioural finder stub (ready=1 idle; 10 busy cycles; returns 17'h1d258 / iteration 1200). Single request on ch2 -> req_ack[2] one pulse, res_valid once with id=2, poly=17'h1d258, iter=1200, found=1.
2. All four channels requesting continuously -> grants in order 0,1,2,3,0; no channel granted twice before the others; exactly one res_valid per ack.
3. Stub returns polynomial 0 (e.g. data=data1=17'h00abc) -> res_found=0, res_polynomial=0, res_iteration=0, res_sensor_id correct.
4. Reset asserted during WAIT_DONE -> pf_enable=0 the next cycle, no res_valid. A new request after reset completes normally.
5. ch1 req_valid pulsed for one cycle while a job is busy -> never acked. ch1 held valid -> acked in the first IDLE cycle after the current res_valid.
6. With POLY_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, stub never raises ready -> after 100 cycles res_valid=1, res_timeout=1, found=0, pf_enable=0.
